// File: rtl/game_io_ctrl.sv
// Memory-mapped game I/O block: LFSR random source, static/queued LED flashing, status register.
// Define GAME_IO_BTN_EN to enable the synchronised sticky button register at ADDR_BTN.

module game_io_ctrl #(
  parameter int          NUM_LEDS     = 4,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          FLASH_CYCLES = 25000000,
  parameter int          GAP_CYCLES   = 12500000,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [11:0] ADDR_RAND    = 12'd5,
  parameter logic [11:0] ADDR_LED     = 12'd6,
  parameter logic [11:0] ADDR_BTN     = 12'd7,
  parameter logic [11:0] ADDR_STATUS  = 12'd8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [11:0]         addr_i,
  input  logic                wren_i,
  input  logic                rden_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                hit_o,
  input  logic [NUM_LEDS-1:0] btn_in_i,
  output logic [NUM_LEDS-1:0] led_out_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_e;

  state_e              state_q, state_d;
  logic [31:0]         timer_q, timer_d;
  logic [7:0]          chan_q, chan_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [NUM_LEDS-1:0] staticLed_q, staticLed_d;
  logic [NUM_LEDS-1:0] ledOut_q, ledOut_d, flashVec;
  logic [7:0]          fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic [31:0]         btnRead;
  logic                unusedBits;

  logic       randSel, ledSel, btnSel, statusSel;
  logic [7:0] storeChan;
  logic       chanOk, ledStore, queueReq, staticReq, errEvent, ovfEvent;
  logic       fifoEmpty, fifoFull, push, pop, busy, statusClr;

  assign randSel   = (addr_i == ADDR_RAND);
  assign ledSel    = (addr_i == ADDR_LED);
  assign btnSel    = (addr_i == ADDR_BTN);
  assign statusSel = (addr_i == ADDR_STATUS);
  assign hit_o     = randSel | ledSel | btnSel | statusSel;

  assign storeChan = wdata_i[8:1];
  assign chanOk    = (storeChan < 8'(NUM_LEDS));
  assign ledStore  = wren_i & ledSel;
  assign queueReq  = ledStore & chanOk & wdata_i[9];
  assign staticReq = ledStore & chanOk & ~wdata_i[9];
  assign errEvent  = ledStore & ~chanOk;

  // A full FIFO still accepts a push when the player pops in the same cycle.
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = (state_q == IDLE) & ~fifoEmpty;
  assign push      = queueReq & (~fifoFull | pop);
  assign ovfEvent  = queueReq & fifoFull & ~pop;
  assign busy      = (state_q != IDLE);
  assign statusClr = rden_i & statusSel;
  assign unusedBits = ^wdata_i[31:10];

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    ovf_d  = (ovf_q & ~statusClr) | ovfEvent;
    err_d  = (err_q & ~statusClr) | errEvent;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    staticLed_d = staticLed_q;
    flashVec    = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (staticReq && storeChan == 8'(i)) staticLed_d[i] = wdata_i[0];
      flashVec[i] = (chan_q == 8'(i));
    end
  end

  // Player FSM; led_out is registered from the current state, so the LED lags the state by one edge.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    chan_d   = chan_q;
    ledOut_d = '0;
    case (state_q)
      IDLE: begin
        ledOut_d = staticLed_q;
        if (!fifoEmpty) begin
          state_d = ON;
          timer_d = '0;
          chan_d  = fifoMem_q[rdPtr_q];
        end
      end
      ON: begin
        ledOut_d = flashVec;
        if (timer_q == 32'(FLASH_CYCLES - 1)) begin
          state_d = GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      GAP: begin
        if (timer_q == 32'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      chan_q      <= '0;
      lfsr_q      <= SEED;
      staticLed_q <= '0;
      ledOut_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      chan_q      <= chan_d;
      lfsr_q      <= lfsr_d;
      staticLed_q <= staticLed_d;
      ledOut_q    <= ledOut_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) fifoMem_q[wrPtr_q] <= storeChan;
  end

  assign led_out_o = ledOut_q;

`ifdef GAME_IO_BTN_EN
  logic [NUM_LEDS-1:0] btnSync1_q, btnSync2_q, btnPrev_q, btn_q, btn_d;

  // A rising edge arriving in the same cycle as the clearing read survives the clear.
  always_comb begin
    btn_d = ((rden_i && btnSel) ? '0 : btn_q) | (btnSync2_q & ~btnPrev_q);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      btnSync1_q <= '0;
      btnSync2_q <= '0;
      btnPrev_q  <= '0;
      btn_q      <= '0;
    end else begin
      btnSync1_q <= btn_in_i;
      btnSync2_q <= btnSync1_q;
      btnPrev_q  <= btnSync2_q;
      btn_q      <= btn_d;
    end
  end

  assign btnRead = 32'(btn_q);
`else
  logic unusedBtn;
  assign unusedBtn = ^btn_in_i;
  assign btnRead   = '0;
`endif

  always_comb begin
    rdata_o = '0;
    if (randSel) begin
      rdata_o = {16'h0000, lfsr_q};
    end else if (ledSel) begin
      rdata_o = 32'(staticLed_q);
    end else if (btnSel) begin
      rdata_o = btnRead;
    end else if (statusSel) begin
      rdata_o = {16'h0000, 8'(count_q), 3'b000, err_q, ovf_q, busy, fifoFull, fifoEmpty};
    end
  end

endmodule

// File: tb/tb_game_io_ctrl.sv
// Scoreboard bench for game_io_ctrl: random bus traffic checked against a queue-based model.
// Build with GAME_IO_BTN_EN defined to also exercise the button register.

module tb_game_io_ctrl;

  localparam int          NUM_LEDS = 4;
  localparam int          DEPTH    = 8;
  localparam int          FLASH    = 10;
  localparam int          GAP      = 4;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [11:0] A_RAND   = 12'd5;
  localparam logic [11:0] A_LED    = 12'd6;
  localparam logic [11:0] A_BTN    = 12'd7;
  localparam logic [11:0] A_STATUS = 12'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] addr = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  btnIn = '0;
  logic [3:0]  ledOut;

  always #5 clk = ~clk;

  game_io_ctrl #(
    .NUM_LEDS(NUM_LEDS), .FIFO_DEPTH(DEPTH), .FLASH_CYCLES(FLASH),
    .GAP_CYCLES(GAP), .SEED(SEED)
  ) dut (
    .clock_i(clk), .reset_i(rst), .addr_i(addr), .wren_i(wren), .rden_i(rden),
    .wdata_i(wdata), .rdata_o(rdata), .hit_o(hit), .btn_in_i(btnIn), .led_out_o(ledOut)
  );

  int   compared = 0;
  int   mismatched = 0;
  bit   checking = 1'b0;
  logic [31:0] expRdataQ[$];
  logic        expHitQ[$];

  // Reference model: FIFO as a queue, a flash as "lit cycles left" then "dark cycles left".
  logic [15:0] mLfsr = SEED;
  logic [3:0]  mStatic = '0;
  logic [3:0]  mLed = '0;
  bit          mOvf = 1'b0;
  bit          mErr = 1'b0;
  int          mQ[$];
  int          mLit = 0;
  int          mDark = 0;
  int          mChan = 0;

  always @(posedge clk) begin
    logic [3:0] ledNext;
    int         chan;
    bit         idle;
    if (rst) begin
      mLfsr = SEED; mStatic = '0; mLed = '0; mOvf = 1'b0; mErr = 1'b0;
      mQ.delete(); mLit = 0; mDark = 0; mChan = 0;
    end else begin
      idle = (mLit == 0 && mDark == 0);
      if (mLit > 0) ledNext = 4'b0001 << mChan;
      else if (mDark > 0) ledNext = 4'b0000;
      else ledNext = mStatic;
      if (rden && addr == A_STATUS) begin
        mOvf = 1'b0;
        mErr = 1'b0;
      end
      if (idle && mQ.size() > 0) begin
        mChan = mQ.pop_front();
        mLit = FLASH;
      end else if (mLit > 0) begin
        mLit--;
        if (mLit == 0) mDark = GAP;
      end else if (mDark > 0) begin
        mDark--;
      end
      if (wren && addr == A_LED) begin
        chan = int'(wdata[8:1]);
        if (chan >= NUM_LEDS) mErr = 1'b1;
        else if (wdata[9]) begin
          if (mQ.size() < DEPTH) mQ.push_back(chan);
          else mOvf = 1'b1;
        end else mStatic[chan] = wdata[0];
      end
      mLed = ledNext;
      mLfsr = {1'b0, mLfsr[15:1]} ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  function automatic logic modelHit(input logic [11:0] a);
    return (a == A_RAND) || (a == A_LED) || (a == A_BTN) || (a == A_STATUS);
  endfunction

  function automatic logic [31:0] modelRead(input logic [11:0] a);
    logic [31:0] v;
    v = '0;
    if (a == A_RAND) v = {16'h0000, mLfsr};
    else if (a == A_LED) v = {28'h0, mStatic};
    else if (a == A_STATUS)
      v = {16'h0000, 8'(mQ.size()), 3'b000, mErr, mOvf,
           (mLit > 0 || mDark > 0), (mQ.size() == DEPTH), (mQ.size() == 0)};
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("led_out", {28'h0, ledOut}, {28'h0, mLed});
    if (rden) begin
      if (expRdataQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard at %0t: got a read with no expectation queued", $time);
      end else begin
        checkValue("rdata", rdata, expRdataQ.pop_front());
        checkValue("hit", {31'h0, hit}, {31'h0, expHitQ.pop_front()});
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (checking) checkOutput();
    end
  end

  task automatic applyStimulus(input logic r, input logic [11:0] a, input logic we,
                               input logic re, input logic [31:0] d);
    @(negedge clk);
    rst = r; addr = a; wren = we; rden = re; wdata = d;
    if (re) begin
      expRdataQ.push_back(modelRead(a));
      expHitQ.push_back(modelHit(a));
    end
  endtask

  task automatic readConst(input logic [11:0] a, input logic [31:0] v, input logic h);
    @(negedge clk);
    rst = 1'b0; addr = a; wren = 1'b0; rden = 1'b1; wdata = '0;
    expRdataQ.push_back(v);
    expHitQ.push_back(h);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [11:0] ra;
    int          r, pushProb, sel;

    applyStimulus(1'b1, 12'h000, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 12'h000, 1'b0, 1'b0, 32'h0);
    checking = 1'b1;

    readConst(A_RAND, 32'h0000ACE1, 1'b1);
    readConst(A_RAND, 32'h0000E270, 1'b1);
    readConst(A_STATUS, 32'h00000001, 1'b1);
    readConst(12'h123, 32'h00000000, 1'b0);

    applyStimulus(1'b0, A_LED, 1'b1, 1'b0, 32'h00000204);
    applyStimulus(1'b0, A_LED, 1'b1, 1'b0, 32'h00000200);
    readConst(A_STATUS, 32'h00000104, 1'b1);
    idleCycles(40);
    readConst(A_STATUS, 32'h00000001, 1'b1);

    applyStimulus(1'b0, A_LED, 1'b1, 1'b0, 32'h00000003);
    applyStimulus(1'b0, A_LED, 1'b1, 1'b0, 32'h00000206);
    idleCycles(20);
    readConst(A_LED, 32'h00000002, 1'b1);

    applyStimulus(1'b0, A_LED, 1'b1, 1'b0, 32'h0000020A);
    readConst(A_STATUS, 32'h00000011, 1'b1);
    readConst(A_STATUS, 32'h00000001, 1'b1);

    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, A_LED, 1'b1, 1'b0, 32'h00000200 | 32'((k % 4) << 1));
    readConst(A_STATUS, 32'h0000080E, 1'b1);
    readConst(A_STATUS, 32'h00000806, 1'b1);
    idleCycles(150);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      pushProb = ((i / 250) % 2 == 0) ? 45 : 8;
      rnd = $urandom();
`ifndef GAME_IO_BTN_EN
      btnIn = 4'($urandom_range(0, 15));
`endif
      if (r == 99) begin
        applyStimulus(1'b1, 12'h000, 1'b0, 1'b0, 32'h0);
      end else if (r < pushProb) begin
        applyStimulus(1'b0, A_LED, 1'b1, 1'b0,
                      {rnd[31:10], 1'b1, 8'($urandom_range(0, 5)), rnd[0]});
      end else if (r < pushProb + 10) begin
        applyStimulus(1'b0, A_LED, 1'b1, 1'b0,
                      {rnd[31:10], 1'b0, 8'($urandom_range(0, 4)), rnd[0]});
      end else if (r < pushProb + 40) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: ra = A_RAND;
          1: ra = A_LED;
          2: ra = A_BTN;
          3: ra = A_STATUS;
          default: ra = 12'($urandom_range(0, 4095));
        endcase
        applyStimulus(1'b0, ra, 1'b0, 1'b1, 32'h0);
      end else if (r < pushProb + 45) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: ra = A_RAND;
          1: ra = A_BTN;
          2: ra = A_STATUS;
          default: ra = 12'($urandom_range(0, 4095));
        endcase
        applyStimulus(1'b0, ra, 1'b1, 1'b0, rnd);
      end else begin
        applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
      end
    end
    btnIn = '0;
    idleCycles(2);

`ifdef GAME_IO_BTN_EN
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
    btnIn = 4'h8;
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
    btnIn = 4'h0;
    idleCycles(4);
    readConst(A_BTN, 32'h00000008, 1'b1);
    readConst(A_BTN, 32'h00000000, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
    btnIn = 4'h8;
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 32'h0);
    readConst(A_BTN, 32'h00000000, 1'b1);
    readConst(A_BTN, 32'h00000008, 1'b1);
    btnIn = 4'h0;
`else
    readConst(A_BTN, 32'h00000000, 1'b1);
`endif
    idleCycles(3);

    checkValue("leftover_expectations", 32'(expRdataQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
